xy_switch_allocator: RTL and testbench

//  Wormhole switch allocator for the 5-port mesh router.
//  - Consumes the per-input one-hot direction requests made by the XY route logic.
//  - Grants each output port to one input at a time with round-robin fairness.
//  - Holds each grant from the head flit through the tail flit.
//  - Drives the crossbar select lines and the per-input flit acknowledge.

---
 rtl/noc_pkg.sv | 18 +
 rtl/sa_rr_arbiter.sv | 33 +++
 rtl/xy_switch_allocator.sv | 150 +++++++++++++++
 tb/tb_xy_switch_allocator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port mesh router: port count, direction indices
// and the switch-allocator output FSM encoding.
package noc_pkg;

  localparam int unsigned NP = 5;

  localparam int unsigned DIR_RIGHT = 0;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_UP    = 2;
  localparam int unsigned DIR_DOWN  = 3;
  localparam int unsigned DIR_EJECT = 4;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_e;

endpackage

// File: rtl/sa_rr_arbiter.sv
// Round-robin picker for one output port: first set request bit scanning from
// the pointer upward, wrapping at NP-1.
module sa_rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NP    = 5,
  parameter int unsigned PTR_W = 3
) (
  input  logic [NP-1:0]    i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NP-1:0]    o_gnt,
  output logic             o_found
);

  localparam logic [PTR_W-1:0] LastIdx = PTR_W'(NP - 1);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    o_found = 1'b0;
    w_idx   = i_ptr;
    for (int k = 0; k < NP; k++) begin
      if (!o_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_found      = 1'b1;
      end
      // NP need not be a power of two, so wrap explicitly
      w_idx = (w_idx == LastIdx) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/xy_switch_allocator.sv
// Wormhole switch allocator: per-output IDLE/LOCKED FSM holding a grant from head
// to tail flit. Define SA_REQ_CHECK_EN to add the err_req non-one-hot request flag.
module xy_switch_allocator #(
  parameter int unsigned NP    = noc_pkg::NP,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NP*NP-1:0] in_req,
  input  logic [NP-1:0]    in_valid,
  input  logic [NP-1:0]    in_tail,
  input  logic [NP-1:0]    out_ready,
  output logic [NP*NP-1:0] out_sel,
  output logic [NP-1:0]    out_valid,
  output logic [NP-1:0]    in_ack
`ifdef SA_REQ_CHECK_EN
  ,
  output logic [NP-1:0]    err_req
`endif
);

  import noc_pkg::*;

  sa_state_e        r_state     [NP];
  sa_state_e        w_state_nxt [NP];
  logic [PTR_W-1:0] r_ptr       [NP];
  logic [PTR_W-1:0] w_ptr_nxt   [NP];
  logic [PTR_W-1:0] w_ptr_after [NP];
  logic [NP-1:0]    w_cand      [NP];
  logic [NP-1:0]    w_gnt       [NP];
  logic [NP*NP-1:0] r_sel;
  logic [NP*NP-1:0] w_sel_nxt;
  logic [NP-1:0]    w_row_ok;
  logic [NP-1:0]    w_in_locked;
  logic [NP-1:0]    w_xfer;
  logic [NP-1:0]    w_tail_xfer;
  logic [NP-1:0]    w_found;

  // An input is locked while any output row of the crossbar select points at it
  always_comb begin
    w_in_locked = '0;
    for (int i = 0; i < NP; i++) begin
      w_row_ok[i] = $onehot(in_req[i*NP +: NP]);
      for (int d = 0; d < NP; d++) begin
        w_in_locked[i] = w_in_locked[i] | r_sel[d*NP+i];
      end
    end
    for (int d = 0; d < NP; d++) begin
      for (int i = 0; i < NP; i++) begin
        w_cand[d][i] = in_valid[i] & in_req[i*NP+d] & w_row_ok[i] & ~w_in_locked[i];
      end
    end
  end

  for (genvar d = 0; d < NP; d++) begin : g_arb
    sa_rr_arbiter #(
      .NP   (NP),
      .PTR_W(PTR_W)
    ) u_arb (
      .i_req  (w_cand[d]),
      .i_ptr  (r_ptr[d]),
      .o_gnt  (w_gnt[d]),
      .o_found(w_found[d])
    );
  end

  // Reset suppresses transfers in its own cycle so no flit is acked mid-reset
  always_comb begin
    in_ack = '0;
    for (int d = 0; d < NP; d++) begin
      w_xfer[d]      = ~reset & (r_state[d] == SA_LOCKED) & out_ready[d] &
                       (|(r_sel[d*NP +: NP] & in_valid));
      w_tail_xfer[d] = w_xfer[d] & (|(r_sel[d*NP +: NP] & in_tail));
      in_ack         = in_ack | ({NP{w_xfer[d]}} & r_sel[d*NP +: NP]);
      w_ptr_after[d] = '0;
      for (int i = 0; i < NP; i++) begin
        if (r_sel[d*NP+i]) begin
          w_ptr_after[d] = (i == NP - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  always_comb begin
    w_sel_nxt = r_sel;
    for (int d = 0; d < NP; d++) begin
      w_state_nxt[d] = r_state[d];
      w_ptr_nxt[d]   = r_ptr[d];
      case (r_state[d])
        SA_IDLE: begin
          if (w_found[d]) begin
            w_state_nxt[d]          = SA_LOCKED;
            w_sel_nxt[d*NP +: NP]   = w_gnt[d];
          end
        end
        SA_LOCKED: begin
          if (w_tail_xfer[d]) begin
            w_state_nxt[d]          = SA_IDLE;
            w_sel_nxt[d*NP +: NP]   = '0;
            w_ptr_nxt[d]            = w_ptr_after[d];
          end
        end
        default: w_state_nxt[d] = SA_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel <= '0;
      for (int d = 0; d < NP; d++) begin
        r_state[d] <= SA_IDLE;
        r_ptr[d]   <= '0;
      end
    end else begin
      r_sel   <= w_sel_nxt;
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign out_sel   = r_sel;
  assign out_valid = w_xfer;

`ifdef SA_REQ_CHECK_EN
  logic [NP-1:0] r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err <= in_valid & ~w_row_ok & ~w_in_locked;
    end
  end

  assign err_req = r_err;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (!reset && in_valid[i] && !w_row_ok[i] && !w_in_locked[i]) begin
        $display("xy_switch_allocator: input %0d request row %b is not one-hot",
                 i, in_req[i*NP +: NP]);
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_xy_switch_allocator.sv
// Randomized bench for xy_switch_allocator against a packet-level reference model
// (per-output owner and round-robin pointer), plus short directed scenarios.
module tb_xy_switch_allocator;

  localparam int NP = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*NP-1:0] in_req;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_tail;
  logic [NP-1:0]    out_ready;
  logic [NP*NP-1:0] out_sel;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    in_ack;
`ifdef SA_REQ_CHECK_EN
  logic [NP-1:0]    err_req;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: owner input per output (-1 = idle) and round-robin pointer
  int            m_owner [NP];
  int            m_ptr   [NP];
  logic [NP-1:0] m_err;

  // Traffic generator: one packet per input
  int            g_len   [NP];
  int            g_sent  [NP];
  int            g_dest  [NP];
  int            g_bad   [NP];
  logic [NP-1:0] g_badrow[NP];

  always #5 clk = ~clk;

  xy_switch_allocator #(
    .NP   (NP),
    .PTR_W(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .in_valid (in_valid),
    .in_tail  (in_tail),
    .out_ready(out_ready),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .in_ack   (in_ack)
`ifdef SA_REQ_CHECK_EN
    ,
    .err_req  (err_req)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic new_pkt(input int i);
    logic [NP-1:0] r;
    g_len[i]  = $urandom_range(1, 4);
    g_sent[i] = 0;
    g_dest[i] = $urandom_range(0, NP - 1);
    g_bad[i]  = 0;
    if ($urandom_range(0, 7) == 0) begin
      do r = NP'($urandom_range(0, 31)); while ($countones(r) == 1);
      g_badrow[i] = r;
      g_bad[i]    = $urandom_range(1, 6);
    end
  endtask

  task automatic set_pkt(input int i, input int dest, input int len);
    g_len[i]  = len;
    g_sent[i] = 0;
    g_dest[i] = dest;
    g_bad[i]  = 0;
  endtask

  task automatic drive(input logic rst, input logic [NP-1:0] vmask, input logic [NP-1:0] rdy,
                       input bit rnd);
    logic [NP-1:0] row;
    reset = rst;
    for (int i = 0; i < NP; i++) begin
      row = '0;
      if (g_bad[i] > 0) row = g_badrow[i];
      else row[g_dest[i]] = 1'b1;
      in_req[i*NP +: NP] = row;
      in_tail[i]  = (g_sent[i] == g_len[i] - 1);
      in_valid[i] = vmask[i] && (!rnd || $urandom_range(0, 3) != 0);
    end
    out_ready = rnd ? NP'($urandom_range(0, 31)) : rdy;
  endtask

  // Check outputs mid-cycle, then advance the model and generator to the next edge
  task automatic cycle();
    int            own_n [NP];
    int            j;
    logic [NP-1:0] locked, e_ack, e_val, row;
    logic [NP*NP-1:0] e_sel;
    @(negedge clk);
    locked = '0;
    e_ack  = '0;
    e_val  = '0;
    e_sel  = '0;
    for (int d = 0; d < NP; d++) begin
      if (m_owner[d] >= 0) begin
        locked[m_owner[d]] = 1'b1;
        e_sel[d*NP + m_owner[d]] = 1'b1;
        if (!reset && in_valid[m_owner[d]] && out_ready[d]) begin
          e_val[d] = 1'b1;
          e_ack[m_owner[d]] = 1'b1;
        end
      end
    end
    check_eq("out_sel", 32'(out_sel), 32'(e_sel));
    check_eq("out_valid", 32'(out_valid), 32'(e_val));
    check_eq("in_ack", 32'(in_ack), 32'(e_ack));
`ifdef SA_REQ_CHECK_EN
    check_eq("err_req", 32'(err_req), 32'(m_err));
`endif
    for (int d = 0; d < NP; d++) begin
      own_n[d] = m_owner[d];
      if (m_owner[d] >= 0) begin
        if (e_val[d] && in_tail[m_owner[d]]) begin
          own_n[d] = -1;
          m_ptr[d] = (m_owner[d] + 1) % NP;
        end
      end else begin
        for (int k = 0; k < NP; k++) begin
          j   = (m_ptr[d] + k) % NP;
          row = in_req[j*NP +: NP];
          if (own_n[d] < 0 && in_valid[j] && !locked[j] && $countones(row) == 1 && row[d])
            own_n[d] = j;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      m_err[i] = in_valid[i] && $countones(in_req[i*NP +: NP]) != 1 && !locked[i];
    end
    if (reset) begin
      m_err = '0;
      for (int d = 0; d < NP; d++) begin
        own_n[d] = -1;
        m_ptr[d] = 0;
      end
      for (int i = 0; i < NP; i++) new_pkt(i);
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (g_bad[i] > 0) g_bad[i]--;
        if (e_ack[i]) begin
          g_sent[i]++;
          if (g_sent[i] == g_len[i]) new_pkt(i);
        end
      end
    end
    m_owner = own_n;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rst, input logic [NP-1:0] vmask, input logic [NP-1:0] rdy,
                      input bit rnd);
    drive(rst, vmask, rdy, rnd);
    cycle();
  endtask

  initial begin
    reset     = 1'b1;
    in_req    = '0;
    in_valid  = '0;
    in_tail   = '0;
    out_ready = '0;
    m_err     = '0;
    for (int d = 0; d < NP; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      new_pkt(d);
    end
    @(posedge clk);
    #1;
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);

    // Single-flit packet, input 0 to Right
    set_pkt(0, 0, 1);
    repeat (4) step(1'b0, 5'b00001, 5'b11111, 1'b0);

    // Inputs 1 and 3 contend for Up with 3-flit packets
    step(1'b1, '0, '0, 1'b0);
    set_pkt(1, 2, 3);
    set_pkt(3, 2, 3);
    repeat (10) step(1'b0, 5'b01010, 5'b11111, 1'b0);

    // 4-flit packet with downstream ready toggling
    step(1'b1, '0, '0, 1'b0);
    set_pkt(0, 1, 4);
    for (int c = 0; c < 10; c++) step(1'b0, 5'b00001, (c % 2 == 0) ? 5'b11111 : 5'b00000, 1'b0);

    // Parallel locks: input 0 to Left, input 2 to Eject
    step(1'b1, '0, '0, 1'b0);
    set_pkt(0, 1, 2);
    set_pkt(2, 4, 2);
    repeat (4) step(1'b0, 5'b00101, 5'b11111, 1'b0);

    // Input 4 with a two-hot request stalls
    step(1'b1, '0, '0, 1'b0);
    set_pkt(4, 0, 1);
    g_bad[4]    = 100;
    g_badrow[4] = 5'b00110;
    repeat (6) step(1'b0, 5'b10000, 5'b11111, 1'b0);

    // Reset on the second flit of a locked packet
    step(1'b1, '0, '0, 1'b0);
    set_pkt(0, 0, 4);
    repeat (2) step(1'b0, 5'b00001, 5'b11111, 1'b0);
    step(1'b1, 5'b00001, 5'b11111, 1'b0);
    repeat (3) step(1'b0, 5'b00001, 5'b11111, 1'b0);

    // Random traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 99) == 0), 5'b11111, '0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
